// File: rtl/stage_sequencer.sv
// Four-phase stage generator with run/halt/single-step control and a retired-instruction counter.
// Latency: 4*STAGE_CYCLES cycles per instruction; first stage begins the cycle after run/step is sampled.
// Backpressure: ready=0 in a stage's final sub-cycle stretches that stage one cycle at a time.
`timescale 1ns/1ps

module stage_sequencer #(
  parameter int STAGE_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 ready,
  output logic [0:3]           is_stage,
  output logic [0:3]           stage_done,
  output logic                 running,
  output logic                 halt_lock,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int SUB_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STAGE_CYCLES - 1);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t           state;
  logic [SUB_W-1:0] sub;
  logic             halt_flag;  // sticky: a HLT was seen during the current instruction
  logic             last_sub;
  logic             advance;
  logic             boundary;

  // A stage completes on its final sub-cycle when memory is ready; halted never advances.
  assign last_sub   = (sub == SUB_LAST);
  assign advance    = last_sub & ready & (state != HALTED);
  assign stage_done = advance ? is_stage : 4'b0000;
  assign boundary   = advance & is_stage[3];

  // Sequencer state, stage rotation, halt handling and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HALTED;
      is_stage    <= 4'b1000;
      sub         <= '0;
      running     <= 1'b0;
      halt_lock   <= 1'b0;
      halt_flag   <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        HALTED: begin
          // run has priority; a simultaneous step is simply dropped
          if (run && !halt_lock) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step) begin
            state   <= STEP;
            running <= 1'b1;
          end
        end
        RUN, STEP: begin
          if (halt_req) halt_flag <= 1'b1;
          if (!last_sub) begin
            sub <= sub + SUB_W'(1);
          end else if (ready) begin
            sub      <= '0;
            is_stage <= {is_stage[3], is_stage[0:2]};
          end
          if (boundary) begin
            instr_count <= instr_count + CNT_WIDTH'(1);
            // a HLT arriving in the very last cycle still counts for this boundary
            if (halt_flag || halt_req) begin
              state     <= HALTED;
              running   <= 1'b0;
              halt_lock <= 1'b1;
              halt_flag <= 1'b0;
            end else if (state == STEP || !run) begin
              state   <= HALTED;
              running <= 1'b0;
            end
          end
        end
        default: begin
          state   <= HALTED;
          running <= 1'b0;
        end
      endcase
      // releasing run always unlocks, overriding a lock set in the same cycle
      if (!run) halt_lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps

module tb_stage_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic       halt_req;
  logic       ready;
  logic [0:3] is_stage;
  logic [0:3] stage_done;
  logic       running;
  logic       halt_lock;
  logic [3:0] instr_count;

  stage_sequencer #(.STAGE_CYCLES(2), .CNT_WIDTH(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .ready       (ready),
    .is_stage    (is_stage),
    .stage_done  (stage_done),
    .running     (running),
    .halt_lock   (halt_lock),
    .instr_count (instr_count)
  );

  typedef struct {
    int         cyc;
    logic [3:0] done;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc;
  int         n_vec;
  int         n_err;
  logic [3:0] model_cnt;
  int         e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ev(input int c, input logic [3:0] d, input logic [3:0] n);
    exp_t x;
    x.cyc  = c;
    x.done = d;
    x.cnt  = n;
    exp_q.push_back(x);
  endtask

  // One instruction whose first cycle follows edge e; w wait cycles land in stage1.
  task automatic push_instr(input int s, input int w);
    push_ev(s + 1,     4'b1000, model_cnt);
    push_ev(s + 3 + w, 4'b0100, model_cnt);
    push_ev(s + 5 + w, 4'b0010, model_cnt);
    push_ev(s + 7 + w, 4'b0001, model_cnt);
    model_cnt = model_cnt + 4'd1;
  endtask

  // Monitor: every stage_done pulse must match the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      check("is_stage_onehot", 64'($onehot(is_stage)), 64'd1);
      if (stage_done != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {32'(cyc), 28'(stage_done), instr_count}, 64'd0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("pulse{cyc,done,cnt}", {32'(cyc), 28'(stage_done), instr_count},
                {32'(x.cyc), 28'(x.done), x.cnt});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    model_cnt = 4'd0;
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; ready = 1'b1;
    repeat (3) tick();
    check("rst_is_stage",   64'(is_stage),    64'h8);
    check("rst_stage_done", 64'(stage_done),  64'h0);
    check("rst_running",    64'(running),     64'h0);
    check("rst_halt_lock",  64'(halt_lock),   64'h0);
    check("rst_count",      64'(instr_count), 64'h0);
    reset = 1'b0;
    tick();

    // free run: four instructions, run dropped in stage1 of the fourth
    run = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 4; j++) push_instr(e + 8 * j, 0);
    wait_cyc(e);
    check("run_start_running", 64'(running),  64'h1);
    check("run_start_stage",   64'(is_stage), 64'h8);
    wait_cyc(e + 26);
    run = 1'b0;
    wait_cyc(e + 33);
    check("run_stop_running", 64'(running),     64'h0);
    check("run_stop_count",   64'(instr_count), 64'(model_cnt));
    check("run_stop_stage",   64'(is_stage),    64'h8);

    // wait states: ready low three cycles in stage1's final sub-cycle
    run = 1'b1;
    e = cyc + 1;
    push_instr(e, 3);
    wait_cyc(e + 1);
    run = 1'b0;
    wait_cyc(e + 3);
    ready = 1'b0;
    wait_cyc(e + 6);
    ready = 1'b1;
    wait_cyc(e + 12);
    check("ws_running", 64'(running),     64'h0);
    check("ws_count",   64'(instr_count), 64'(model_cnt));

    // single step; a second step while running is ignored
    step = 1'b1;
    tick();
    step = 1'b0;
    e = cyc;
    push_instr(e, 0);
    check("step_running", 64'(running), 64'h1);
    wait_cyc(e + 3);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_cyc(e + 9);
    check("step_done_running", 64'(running),     64'h0);
    check("step_done_count",   64'(instr_count), 64'(model_cnt));
    wait_cyc(e + 14);

    // halt instruction in stage2 with run held high
    run = 1'b1;
    e = cyc + 1;
    push_instr(e, 0);
    wait_cyc(e + 4);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_cyc(e + 9);
    check("hlt_running", 64'(running),     64'h0);
    check("hlt_lock",    64'(halt_lock),   64'h1);
    check("hlt_count",   64'(instr_count), 64'(model_cnt));
    wait_cyc(e + 29);
    check("hlt_hold_running", 64'(running),   64'h0);
    check("hlt_hold_lock",    64'(halt_lock), 64'h1);

    // step still works while locked
    step = 1'b1;
    tick();
    step = 1'b0;
    e = cyc;
    push_instr(e, 0);
    wait_cyc(e + 9);
    check("lockstep_running", 64'(running),     64'h0);
    check("lockstep_lock",    64'(halt_lock),   64'h1);
    check("lockstep_count",   64'(instr_count), 64'(model_cnt));

    // release run to unlock, resume, then async reset mid-stage2
    run = 1'b0;
    tick();
    check("unlock", 64'(halt_lock), 64'h0);
    run = 1'b1;
    e = cyc + 1;
    push_ev(e + 1, 4'b1000, model_cnt);
    push_ev(e + 3, 4'b0100, model_cnt);
    wait_cyc(e + 4);
    #1;
    reset = 1'b1;
    #1;
    check("arst_is_stage",   64'(is_stage),    64'h8);
    check("arst_stage_done", 64'(stage_done),  64'h0);
    check("arst_running",    64'(running),     64'h0);
    check("arst_count",      64'(instr_count), 64'h0);
    model_cnt = 4'd0;
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // sixteen instructions wrap the 4-bit counter; run dropped in stage1 of the last
    run = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 16; j++) push_instr(e + 8 * j, 0);
    wait_cyc(e + 8 * 15 + 2);
    run = 1'b0;
    wait_cyc(e + 130);
    check("wrap_running", 64'(running),     64'h0);
    check("wrap_count",   64'(instr_count), 64'(model_cnt));
    check("wrap_stage",   64'(is_stage),    64'h8);
    wait_cyc(e + 136);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Synthesizable single-clock replacement for the behavioural four-phase stage generator. It walks the processor through stage0 (fetch/expand), stage1 (value0 fetch), stage2 (value1 fetch) and stage3 (write-back/PC update). It emits a one-hot stage indicator and per-stage write strobes, and adds run/halt/single-step control, memory wait-state stretching and a retired-instruction counter. It sits between the top-level clock/reset and every stage-gated flip-flop in the datapath.

## Interface
- STAGE_CYCLES, 2: minimum clock cycles per stage; legal range 1..16.
- CNT_WIDTH, 16: width of the retired-instruction counter.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = free-run instructions.
- step  input  1  one-cycle pulse; execute exactly one instruction from halt.
- halt_req  input  1  one-cycle pulse from the datapath (HLT instruction); stop at the next instruction boundary.
- ready  input  1  memory/operand ready; 0 stretches the current stage.
- is_stage  output  [0:3]  one-hot current stage; bit i = stage i.
- stage_done  output  [0:3]  bit i high in the final cycle of stage i; write enable for stage-i flip-flops.
- running  output  1  1 while an instruction is in progress.
- halt_lock  output  1  1 after a halt_req-induced halt, until run is released.
- instr_count  output  CNT_WIDTH  instructions retired (stage3 completions).

## Operation
- Reset values: is_stage=4'b1000, stage_done=0, running=0, halt_lock=0, instr_count=0, sub-cycle counter=0, FSM=HALTED, sticky halt flag=0.
- FSM states and their behaviour:
  - HALTED: is_stage holds stage0, sub=0, no progression. Exit to RUN when run=1 and halt_lock=0. Otherwise exit to STEP on a step pulse.
  - RUN: stages advance continuously.
  - STEP: identical to RUN but returns to HALTED after one instruction.
- Stage advance:
  - sub counts 0..STAGE_CYCLES-1.
  - stage_done[i] = is_stage[i] & (sub==STAGE_CYCLES-1) & ready & (FSM!=HALTED). This is combinational from registered state plus ready; it is the only combinational output.
  - When stage_done is high: sub←0 and is_stage rotates to i+1 (stage3→stage0).
  - When ready=0 in the final sub-cycle: sub and is_stage hold.
  - ready is ignored in non-final sub-cycles.
- Retire: on the stage_done[3] edge, instr_count←instr_count+1, wrapping modulo 2^CNT_WIDTH.
- Instruction boundary (stage_done[3] edge) decision, first match wins:
  1. If sticky halt flag=1: →HALTED, set halt_lock, clear flag.
  2. If FSM=STEP: →HALTED.
  3. If run=0: →HALTED.
  4. Otherwise stay in RUN.
- halt_req:
  - Latched into the sticky flag in any non-HALTED cycle; ignored in HALTED.
  - Never aborts an instruction mid-stage.
- run falling mid-instruction: the current instruction completes, then the FSM halts. Partial instructions never occur.
- halt_lock: cleared in any cycle where run=0. While set, run=1 cannot leave HALTED, but step still executes one instruction.
- run and step both asserted in HALTED: RUN wins and step is dropped.
- step outside HALTED is ignored and not queued.
- running=1 exactly when FSM≠HALTED.

## Timing
- HALTED→RUN: run sampled 1 at edge k. From cycle k+1, running=1 and the bench is at stage0/sub0.
- Throughput with ready=1: one instruction per 4×STAGE_CYCLES cycles. Default is 8 cycles, with stage_done pulses in cycles 2, 4, 6, 8 of each instruction.
- Each ready=0 cycle in a final sub-cycle adds exactly one cycle.
- Boundary halt: at the edge ending stage3, running drops to 0 and is_stage=4'b1000 in the following cycle.
- Asynchronous reset mid-instruction: all outputs return to reset values immediately, no stage_done is emitted, and instr_count is not incremented.
- Reset deassertion: the first FSM decision occurs at the first rising edge after reset falls.

## Test plan
- Free-run: reset, run=1, ready=1, STAGE_CYCLES=2 for 32 cycles → stage_done[0..3] pulse in cycles 2/4/6/8 repeating; instr_count=4; is_stage always one-hot.
- Wait states: ready=0 for 3 cycles in stage1's final sub-cycle → stage1 lasts 5 cycles, that instruction takes 11 cycles, and stage_done[1] pulses exactly once.
- Single-step: run=0, step pulse → exactly 4 stage_done pulses, instr_count 0→1, then running=0; a second step pulse while running is ignored.
- Halt instruction: run=1, halt_req in stage2 → the instruction completes, instr_count+1, running=0, halt_lock=1. With run still 1, the block stays halted for 20 cycles; run 0→1 resumes.
- run drop and counter wrap: CNT_WIDTH=4, run=1 for 16 instructions → instr_count wraps 15→0. run=0 in stage1 → halt after stage3, no extra pulses.
- Async reset asserted mid-stage2 between edges → outputs reach reset values before the next edge, and instr_count=0.
